// File: rtl/m_shiftcounter_pkg.sv
// Shared types and constants for the m_shiftcounter_n shift down-counter.
package m_shiftcounter_pkg;

   typedef enum logic {
      SHC_IDLE = 1'b0,
      SHC_RUN  = 1'b1
   } shc_state_e;

   localparam logic SHC_LD_DIRECT = 1'b0;
   localparam logic SHC_LD_SCALED = 1'b1;

   localparam int SHC_WIDTH_DEF = 5;
   localparam int SHC_SCALE_DEF = 3;

endpackage

// File: rtl/m_shcnt_ldval.sv
// Load-value mux for m_shiftcounter_n: direct or power-of-two scaled count, plus zero flag.
module m_shcnt_ldval
   import m_shiftcounter_pkg::*;
#(
   parameter int WIDTH = SHC_WIDTH_DEF,
   parameter int SCALE = SHC_SCALE_DEF
) (
   input  logic             ldscale_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] v_o,
   output logic             vzero_o
);

   // Shifting within WIDTH bits drops B bits above WIDTH-1-SCALE and also covers SCALE=0.
   always_comb begin
      v_o = b_i;
      if (ldscale_i == SHC_LD_SCALED) begin
         v_o = b_i << SCALE;
      end
      vzero_o = (v_o == '0);
   end

endmodule

// File: rtl/m_shiftcounter_n.sv
// Parametrised shift down-counter with reload, zero-count handling and registered last-step flag.
// Optional stall input enabled by defining M_SHIFTCOUNTER_STALL_EN.
module m_shiftcounter_n
   import m_shiftcounter_pkg::*;
#(
   parameter int WIDTH = SHC_WIDTH_DEF,
   parameter int SCALE = SHC_SCALE_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld,
   input  logic             ldscale,
   input  logic [WIDTH-1:0] B,
`ifdef M_SHIFTCOUNTER_STALL_EN
   input  logic             stall,
`endif
   output logic             busy,
   output logic [WIDTH-1:0] cnt,
   output logic             lastshift,
   output logic             r_issh0
);

   generate
      if (SCALE < 0 || SCALE > WIDTH - 1) begin : g_bad_scale
         $error("m_shiftcounter_n: SCALE must lie in 0..WIDTH-1");
      end
   endgenerate

   shc_state_e       state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             r_issh0_q;
   logic [WIDTH-1:0] ldv;
   logic             ldv_zero;
   logic             hold;
   logic             cnt_is_one;

`ifdef M_SHIFTCOUNTER_STALL_EN
   assign hold = stall;
`else
   assign hold = 1'b0;
`endif

   m_shcnt_ldval #(
      .WIDTH(WIDTH),
      .SCALE(SCALE)
   ) u_ldval (
      .ldscale_i(ldscale),
      .b_i      (B),
      .v_o      (ldv),
      .vzero_o  (ldv_zero)
   );

   assign cnt_is_one = (cnt_q == WIDTH'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= SHC_IDLE;
         cnt_q     <= '0;
         r_issh0_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         r_issh0_q <= lastshift;
      end
   end

   // Reload beats decrement and stall; RUN always holds cnt >= 1, so decrement never wraps.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (ld) begin
         cnt_d   = ldv;
         state_d = ldv_zero ? SHC_IDLE : SHC_RUN;
      end else if (state_q == SHC_RUN && !hold) begin
         cnt_d   = cnt_q - WIDTH'(1);
         state_d = cnt_is_one ? SHC_IDLE : SHC_RUN;
      end
   end

   always_comb begin
      busy      = (state_q == SHC_RUN);
      lastshift = 1'b0;
      if (!rst) begin
         if (ld) begin
            lastshift = ldv_zero;
         end else begin
            lastshift = (state_q == SHC_RUN) && !hold && cnt_is_one;
         end
      end
   end

   assign cnt     = cnt_q;
   assign r_issh0 = r_issh0_q;

endmodule

// File: tb/tb_m_shiftcounter_n.sv
// Directed self-checking bench for m_shiftcounter_n (WIDTH=5, SCALE=3).
module tb_m_shiftcounter_n;

   localparam int WIDTH = 5;
   localparam int SCALE = 3;

   logic             clk;
   logic             rst;
   logic             ld;
   logic             ldscale;
   logic [WIDTH-1:0] B;
   logic             stall;
   logic             busy;
   logic [WIDTH-1:0] cnt;
   logic             lastshift;
   logic             r_issh0;

   int n_chk;
   int n_fail;

   m_shiftcounter_n #(
      .WIDTH(WIDTH),
      .SCALE(SCALE)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ld       (ld),
      .ldscale  (ldscale),
      .B        (B),
`ifdef M_SHIFTCOUNTER_STALL_EN
      .stall    (stall),
`endif
      .busy     (busy),
      .cnt      (cnt),
      .lastshift(lastshift),
      .r_issh0  (r_issh0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are then driven for the new cycle.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk   = 0;
      n_fail  = 0;
      rst     = 1'b1;
      ld      = 1'b1;
      ldscale = 1'b0;
      B       = '0;
      stall   = 1'b0;

      // Reset with a zero-value load pending: no lastshift, no load
      cyc();
      #1 check_val("rst_lastshift", 32'(lastshift), 0);
      cyc();
      #1;
      check_val("rst_cnt", 32'(cnt), 0);
      check_val("rst_busy", 32'(busy), 0);
      check_val("rst_issh0", 32'(r_issh0), 0);
      check_val("rst_lastshift2", 32'(lastshift), 0);

      // Direct load of 5
      rst = 1'b0; ld = 1'b1; ldscale = 1'b0; B = 5'd5;
      #1 check_val("d5_ld_lastshift", 32'(lastshift), 0);
      cyc();
      ld = 1'b0; B = 5'd0;
      for (int k = 1; k <= 5; k++) begin
         #1;
         check_val("d5_busy", 32'(busy), 1);
         check_val("d5_cnt", 32'(cnt), 32'(6 - k));
         check_val("d5_lastshift", 32'(lastshift), 32'(k == 5));
         check_val("d5_issh0", 32'(r_issh0), 0);
         cyc();
      end
      #1;
      check_val("d5_end_issh0", 32'(r_issh0), 1);
      check_val("d5_end_busy", 32'(busy), 0);
      check_val("d5_end_cnt", 32'(cnt), 0);
      check_val("d5_end_lastshift", 32'(lastshift), 0);

      // Scaled load of 3 -> 24 steps
      cyc();
      ld = 1'b1; ldscale = 1'b1; B = 5'd3;
      #1 check_val("s3_ld_lastshift", 32'(lastshift), 0);
      cyc();
      ld = 1'b0; ldscale = 1'b0; B = 5'd0;
      for (int k = 1; k <= 24; k++) begin
         #1;
         check_val("s3_busy", 32'(busy), 1);
         check_val("s3_cnt", 32'(cnt), 32'(25 - k));
         check_val("s3_lastshift", 32'(lastshift), 32'(k == 24));
         cyc();
      end
      #1;
      check_val("s3_end_issh0", 32'(r_issh0), 1);
      check_val("s3_end_busy", 32'(busy), 0);

      // Scaled load whose surviving bits are zero -> immediate completion
      cyc();
      ld = 1'b1; ldscale = 1'b1; B = 5'b11100;
      #1 check_val("sz_lastshift", 32'(lastshift), 1);
      cyc();
      ld = 1'b0; ldscale = 1'b0; B = 5'd0;
      #1;
      check_val("sz_issh0", 32'(r_issh0), 1);
      check_val("sz_busy", 32'(busy), 0);
      check_val("sz_cnt", 32'(cnt), 0);

      // Direct zero load
      cyc();
      ld = 1'b1; B = 5'd0;
      #1 check_val("dz_lastshift", 32'(lastshift), 1);
      cyc();
      ld = 1'b0;
      #1;
      check_val("dz_issh0", 32'(r_issh0), 1);
      check_val("dz_busy", 32'(busy), 0);
      cyc();
      #1 check_val("dz_issh0_clr", 32'(r_issh0), 0);

      // Reload of 2 at cnt=1 of a 4-step sequence
      ld = 1'b1; B = 5'd4;
      cyc();
      ld = 1'b0;
      cyc();
      cyc();
      cyc();
      ld = 1'b1; B = 5'd2;
      #1;
      check_val("rl_cnt1", 32'(cnt), 1);
      check_val("rl_drop_lastshift", 32'(lastshift), 0);
      cyc();
      ld = 1'b0;
      #1;
      check_val("rl_cnt2", 32'(cnt), 2);
      check_val("rl_busy", 32'(busy), 1);
      check_val("rl_issh0_drop", 32'(r_issh0), 0);
      check_val("rl_lastshift_early", 32'(lastshift), 0);
      cyc();
      #1;
      check_val("rl_lastshift", 32'(lastshift), 1);
      cyc();
      #1;
      check_val("rl_issh0", 32'(r_issh0), 1);
      check_val("rl_end_busy", 32'(busy), 0);

      // Reset at cnt=2 mid-run
      cyc();
      ld = 1'b1; B = 5'd4;
      cyc();
      ld = 1'b0;
      cyc();
      cyc();
      #1 check_val("rr_cnt_before", 32'(cnt), 2);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      #1;
      check_val("rr_busy", 32'(busy), 0);
      check_val("rr_cnt", 32'(cnt), 0);
      check_val("rr_issh0", 32'(r_issh0), 0);
      check_val("rr_lastshift", 32'(lastshift), 0);
      cyc();
      #1 check_val("rr_issh0_late", 32'(r_issh0), 0);

      // Reset exactly at cnt=1 suppresses the final step
      ld = 1'b1; B = 5'd1;
      cyc();
      ld = 1'b0; rst = 1'b1;
      #1 check_val("r1_lastshift", 32'(lastshift), 0);
      cyc();
      rst = 1'b0;
      #1;
      check_val("r1_issh0", 32'(r_issh0), 0);
      check_val("r1_busy", 32'(busy), 0);

`ifdef M_SHIFTCOUNTER_STALL_EN
      // Stall two cycles at cnt=2: lastshift slips by exactly two cycles
      cyc();
      ld = 1'b1; B = 5'd3;
      cyc();
      ld = 1'b0;
      cyc();
      stall = 1'b1;
      #1 check_val("st_cnt2", 32'(cnt), 2);
      cyc();
      #1 check_val("st_hold", 32'(cnt), 2);
      cyc();
      stall = 1'b0;
      #1;
      check_val("st_hold2", 32'(cnt), 2);
      check_val("st_no_last", 32'(lastshift), 0);
      cyc();
      #1 check_val("st_last", 32'(lastshift), 1);
      cyc();
      #1 check_val("st_issh0", 32'(r_issh0), 1);

      // Stall at cnt=1 holds back lastshift until release
      ld = 1'b1; B = 5'd1;
      cyc();
      ld = 1'b0; stall = 1'b1;
      #1 check_val("s1_suppress", 32'(lastshift), 0);
      cyc();
      #1;
      check_val("s1_busy", 32'(busy), 1);
      check_val("s1_cnt", 32'(cnt), 1);
      check_val("s1_issh0", 32'(r_issh0), 0);
      stall = 1'b0;
      #1 check_val("s1_release", 32'(lastshift), 1);
      cyc();
      #1 check_val("s1_end_busy", 32'(busy), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
